// File: rtl/stack_unit_if.sv
// Bundles for stack_unit: op handshake from the control unit and the data-memory port.
// master drives the request side of each bundle; slave answers it.
interface stack_op_if #(
   parameter int DATA_W = 16
);
   logic              op_valid;
   logic [1:0]        op;
   logic              op_ready;
   logic [DATA_W-1:0] push_data;
   logic [DATA_W-1:0] pop_data;
   logic              pop_valid;
   logic              err;

   modport master (output op_valid, op, push_data, input op_ready, pop_data, pop_valid, err);
   modport slave  (input op_valid, op, push_data, output op_ready, pop_data, pop_valid, err);
endinterface

interface stack_mem_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
   modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/stack_unit.sv
// Descending hardware stack controller running push/pop (and peek) over a req/ack memory port.
// Optional peek operation (op=10) is enabled by defining STACK_PEEK_EN.
module stack_unit #(
   parameter int              DATA_W      = 16,
   parameter int              ADDR_W      = 16,
   parameter logic [ADDR_W-1:0] STACK_BASE = 16'hFFFF,
   parameter int              STACK_DEPTH = 256
) (
   input  logic              clk,
   input  logic              rst,
   stack_op_if.slave         op_bus,
   stack_mem_if.master       mem_bus,
   output logic [ADDR_W-1:0] sp,
   output logic [16:0]       depth,
   output logic              empty,
   output logic              full
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2
   } state_t;

   localparam logic [16:0] DEPTH_MAX = 17'(STACK_DEPTH);

   state_t            state_r;
   logic [ADDR_W-1:0] sp_r;
   logic [16:0]       depth_r;
   logic [DATA_W-1:0] pop_data_r;
   logic              pop_valid_r;
   logic              err_r;
   logic              op_ready_r;
   logic              peek_r;
   logic              mem_req_r;
   logic              mem_we_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r;
   logic              empty_s;
   logic              full_s;
   logic [ADDR_W-1:0] sp_inc_s;

   assign empty_s  = (depth_r == 17'd0);
   assign full_s   = (depth_r == DEPTH_MAX);
   assign sp_inc_s = sp_r + ADDR_W'(1);

   assign sp    = sp_r;
   assign depth = depth_r;
   assign empty = empty_s;
   assign full  = full_s;

   assign op_bus.op_ready  = op_ready_r;
   assign op_bus.pop_data  = pop_data_r;
   assign op_bus.pop_valid = pop_valid_r;
   assign op_bus.err       = err_r;

   assign mem_bus.mem_req   = mem_req_r;
   assign mem_bus.mem_we    = mem_we_r;
   assign mem_bus.mem_addr  = mem_addr_r;
   assign mem_bus.mem_wdata = mem_wdata_r;

   // Transaction FSM: accepts ops in IDLE, holds the memory request until ack, commits SP/depth on ack.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= IDLE;
         sp_r        <= STACK_BASE;
         depth_r     <= 17'd0;
         pop_data_r  <= '0;
         pop_valid_r <= 1'b0;
         err_r       <= 1'b0;
         op_ready_r  <= 1'b1;
         peek_r      <= 1'b0;
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
      end else begin
         pop_valid_r <= 1'b0;
         err_r       <= 1'b0;
         case (state_r)
            IDLE: begin
               if (op_bus.op_valid && op_ready_r) begin
                  case (op_bus.op)
                     2'b00: begin
                        if (full_s) begin
                           err_r <= 1'b1;
                        end else begin
                           mem_addr_r  <= sp_r;
                           mem_wdata_r <= op_bus.push_data;
                           mem_we_r    <= 1'b1;
                           mem_req_r   <= 1'b1;
                           peek_r      <= 1'b0;
                           op_ready_r  <= 1'b0;
                           state_r     <= WR;
                        end
                     end
                     2'b01: begin
                        if (empty_s) begin
                           err_r <= 1'b1;
                        end else begin
                           mem_addr_r <= sp_inc_s;
                           mem_we_r   <= 1'b0;
                           mem_req_r  <= 1'b1;
                           peek_r     <= 1'b0;
                           op_ready_r <= 1'b0;
                           state_r    <= RD;
                        end
                     end
`ifdef STACK_PEEK_EN
                     2'b10: begin
                        if (empty_s) begin
                           err_r <= 1'b1;
                        end else begin
                           mem_addr_r <= sp_inc_s;
                           mem_we_r   <= 1'b0;
                           mem_req_r  <= 1'b1;
                           peek_r     <= 1'b1;
                           op_ready_r <= 1'b0;
                           state_r    <= RD;
                        end
                     end
`endif
                     default: begin
                        err_r <= 1'b1;
                     end
                  endcase
               end
            end
            WR: begin
               if (mem_bus.mem_ack) begin
                  sp_r       <= sp_r - ADDR_W'(1);
                  depth_r    <= depth_r + 17'd1;
                  mem_req_r  <= 1'b0;
                  op_ready_r <= 1'b1;
                  state_r    <= IDLE;
               end
            end
            RD: begin
               if (mem_bus.mem_ack) begin
                  pop_data_r  <= mem_bus.mem_rdata;
                  pop_valid_r <= 1'b1;
                  // A peek reads the top entry but leaves the stack as it was.
                  if (!peek_r) begin
                     sp_r    <= sp_inc_s;
                     depth_r <= depth_r - 17'd1;
                  end
                  mem_req_r  <= 1'b0;
                  op_ready_r <= 1'b1;
                  state_r    <= IDLE;
               end
            end
            default: begin
               mem_req_r  <= 1'b0;
               op_ready_r <= 1'b1;
               state_r    <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Hardware stack controller for the 16-bit processor, used for CALL/RET and PUSH/POP.
- Owns a descending stack pointer (SP) and runs push/pop transactions against data memory through a req/ack handshake.
- Tracks depth and detects overflow and underflow.
- Sits between the control unit (op handshake) and the data memory port.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 16, memory address width.
- STACK_BASE, 16'hFFFF, SP value when empty; first push writes here.
- STACK_DEPTH, 256, maximum entries, 1..65536.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- op_valid  in  1  operation request.
- op  in  2  00 push, 01 pop, 10 peek (optional feature), 11 reserved.
- op_ready  out  1  unit idle; request is accepted when op_valid && op_ready.
- push_data  in  DATA_W  data to push; sampled at acceptance.
- pop_data  out  DATA_W  data read by pop/peek; holds until the next read completes.
- pop_valid  out  1  one-cycle pulse when pop_data is updated.
- err  out  1  one-cycle pulse: overflow, underflow or reserved op.
- sp  out  ADDR_W  current stack pointer (next free slot).
- depth  out  17  current entry count.
- empty  out  1  depth == 0.
- full  out  1  depth == STACK_DEPTH.
- mem_req  out  1  memory request; held high until mem_ack.
- mem_we  out  1  1 = write, 0 = read; stable while mem_req is high.
- mem_addr  out  ADDR_W  memory address; stable while mem_req is high.
- mem_wdata  out  DATA_W  write data; stable while mem_req is high.
- mem_rdata  in  DATA_W  read data; valid in the mem_ack cycle.
- mem_ack  in  1  memory completion; 1 or more cycles after mem_req rises.

Behaviour:
- Reset (rst low, asynchronous):
  - sp=STACK_BASE, depth=0, empty=1, full=0, op_ready=1.
  - pop_data=0, pop_valid=0, err=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - State IDLE. Reset mid-transaction drops mem_req immediately and abandons the transaction; SP and depth are not updated.
- States: IDLE, WR, RD.
- IDLE, op_ready=1. On acceptance:
  - Push, not full: mem_addr=sp, mem_wdata=push_data, mem_we=1, mem_req=1, go to WR.
  - Push while full: no memory access, err pulses next cycle, stay IDLE.
  - Pop, not empty: mem_addr=sp+1 (modulo 2^ADDR_W), mem_we=0, mem_req=1, go to RD.
  - Pop while empty: err pulse, stay IDLE.
  - op=11: err pulse, stay IDLE, no state change.
- WR, op_ready=0: on mem_ack, sp<=sp-1 (wraps 0 -> FFFF), depth+1, mem_req<=0, go to IDLE.
- RD, op_ready=0: on mem_ack, pop_data<=mem_rdata, pop_valid pulses the next cycle, sp<=sp+1, depth-1, mem_req<=0, go to IDLE.
- Latency, with mem_ack in the cycle after mem_req rises:
  - Acceptance edge -> mem_req high.
  - Following edge samples ack.
  - op_ready high again 2 cycles after acceptance.
- Back-to-back ops: a new op may be accepted in the first IDLE cycle after completion.
- All memory outputs are registered. mem_addr, mem_we and mem_wdata retain their last values after mem_req falls.
- op_valid while op_ready=0 is ignored. The control unit must hold the request until accepted.
- empty and full are combinational from depth. sp and depth update in the same edge as the ack sample.

Optional Feature:
- Macro: STACK_PEEK_EN.
- Defined:
  - op=10 (peek), when not empty, reads mem[sp+1] via RD.
  - Completion updates pop_data and pulses pop_valid.
  - sp and depth are unchanged.
  - Peek while empty gives an err pulse.
- Not defined: op=10 is treated as reserved (err pulse, no access).

Test Plan:
- Bench parameters: STACK_BASE=16'h00FF, STACK_DEPTH=4, memory model acks 1 cycle after req.
- Reset, then idle: sp=00FF, depth=0, empty=1, op_ready=1, mem_req=0. Assert rst low while in WR -> mem_req=0 immediately, sp=00FF.
- Push 1111, 2222, 3333, 4444 -> writes at 00FF, 00FE, 00FD, 00FC; sp=00FB, full=1. Fifth push 5555 -> err pulse, no mem_req, sp unchanged.
- Pop x4 after the previous test -> pop_data 4444, 3333, 2222, 1111 (read addrs 00FC..00FF), each with one pop_valid pulse; then empty=1, sp=00FF. Fifth pop -> err pulse.
- Memory ack delayed 5 cycles on a push of ABCD -> mem_req, mem_addr and mem_wdata held stable for 5 cycles; op_ready=0 throughout; op_valid pulses during the wait are ignored.
- op=11 in IDLE -> err pulse, sp/depth unchanged. With STACK_PEEK_EN, after push BEEF: peek -> pop_data=BEEF, depth stays 1. Without the macro: peek -> err pulse.
